// File: rtl/sisc_ctrl_fsm.sv
// Multi-cycle control FSM for the SISC datapath: sequences each instruction
// START/FETCH/DECODE/EXECUTE/MEM/WRITEBACK/HALT and drives the datapath strobes.
module sisc_ctrl_fsm #(
    parameter int PC_RST_CYCLES = 2,
    parameter int CC_W          = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      opcode,
    input  logic [CC_W-1:0] mm,
    input  logic [CC_W-1:0] stat,
    output logic            pc_rst,
    output logic            ir_load,
    output logic            pc_write,
    output logic            pc_sel,
    output logic            br_sel,
    output logic            rb_sel,
    output logic [1:0]      alu_op,
    output logic            dm_we,
    output logic            rf_we,
    output logic            wb_sel,
    output logic            halted
);

    localparam logic [2:0] S_START  = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [3:0] OP_ALU = 4'b0001;
    localparam logic [3:0] OP_ALI = 4'b0010;
    localparam logic [3:0] OP_BRA = 4'b0100;
    localparam logic [3:0] OP_BRR = 4'b0101;
    localparam logic [3:0] OP_LOD = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [3:0] CNT_LAST = 4'(PC_RST_CYCLES - 1);

    logic [2:0] r_state;
    logic [3:0] r_cnt;
    logic [2:0] w_state_nxt;
    logic       w_taken;
    logic       w_is_br;
    logic       w_is_str;
    logic [1:0] w_alu_op;

    assign w_taken  = |(mm & stat);
    assign w_is_br  = (opcode == OP_BRA) || (opcode == OP_BRR);
    assign w_is_str = (opcode == OP_STR);

    always_comb begin
        case (opcode)
            OP_ALU:         w_alu_op = 2'b00;
            OP_ALI:         w_alu_op = 2'b01;
            OP_LOD, OP_STR: w_alu_op = 2'b10;
            default:        w_alu_op = 2'b11;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_START:  w_state_nxt = (r_cnt == CNT_LAST) ? S_FETCH : S_START;
            S_FETCH:  w_state_nxt = S_DECODE;
            S_DECODE: w_state_nxt = (opcode == OP_HLT) ? S_HALT : S_EXEC;
            S_EXEC:   w_state_nxt = S_MEM;
            S_MEM:    w_state_nxt = S_WB;
            S_WB:     w_state_nxt = S_FETCH;
            S_HALT:   w_state_nxt = S_HALT;
            default:  w_state_nxt = S_START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_START;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (r_state == S_START) ? r_cnt + 4'd1 : 4'd0;
        end
    end

    // rst overrides the state decode so no strobe escapes while reset is pending
    always_comb begin
        pc_rst   = 1'b0;
        ir_load  = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
        rb_sel   = 1'b0;
        alu_op   = 2'b00;
        dm_we    = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        halted   = 1'b0;
        if (rst) begin
            pc_rst = 1'b1;
        end else begin
            case (r_state)
                S_START: pc_rst = 1'b1;
                S_FETCH: begin
                    ir_load  = 1'b1;
                    pc_write = 1'b1;
                end
                S_DECODE: begin
                    rb_sel = w_is_str;
                    if (w_is_br && w_taken) begin
                        pc_write = 1'b1;
                        pc_sel   = 1'b1;
                        br_sel   = (opcode == OP_BRR);
                    end
                end
                S_EXEC: begin
                    alu_op = w_alu_op;
                    rb_sel = w_is_str;
                end
                S_MEM: begin
                    rb_sel = w_is_str;
                    dm_we  = w_is_str;
                end
                S_WB: begin
                    alu_op = w_alu_op;
                    rf_we  = (opcode == OP_ALU) || (opcode == OP_ALI) || (opcode == OP_LOD);
                    wb_sel = (opcode == OP_LOD);
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
